mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Data-memory responder for the MEM stage: accepts one 32-bit load/store request at a time and
//  runs it over the 8-bit RAM port, one byte per cycle, little-endian. Sits between mem and RAM.
//  Drives stall_o so the pipeline holds while a request is in flight.
//  Returns load data, zero- or sign-extended, with a one-cycle ready_o pulse.
// PARAMETERS
//  RAM_AW   17   RAM byte-address width; ram_a_o = low RAM_AW bits of the byte address
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       synchronous, active-low reset (0 = reset, sampled on clk rising edge)
//  req_i       in   1       request valid from mem; held until ready_o
//  we_i        in   1       1 = store, 0 = load
//  size_i      in   2       00 byte, 01 half, 10 word, 11 treated as word
//  sext_i      in   1       load only: 1 = sign-extend byte/half, 0 = zero-extend
//  addr_i      in   32      byte address; alignment not checked
//  wdata_i     in   32      store data; low 8/16/32 bits used per size_i
//  rdata_o     out  32      load result; valid only while ready_o=1
//  ready_o     out  1       one-cycle completion pulse (load and store)
//  stall_o     out  1       combinational: req_i & ~ready_o
//  ram_a_o     out  RAM_AW  RAM byte address
//  ram_wr_o    out  1       1 = write ram_dout_o at ram_a_o this cycle
//  ram_dout_o  out  8       RAM write byte
//  ram_din_i   in   8       RAM read byte, valid one cycle after ram_a_o presented
// BEHAVIOUR
//  - Reset (rst=0 at edge): state IDLE; ram_a_o=0, ram_wr_o=0, ram_dout_o=0, rdata_o=0, ready_o=0,
//    byte counter=0. Reset mid-operation aborts it; no further RAM writes issued after that edge.
//  - N = 1/2/4 bytes for size 00/01/1x. Byte k at address addr_i+k (mod 2^RAM_AW), k=0..N-1.
//  - FSM: IDLE -> (req_i & we_i) STORE | (req_i & ~we_i) LOAD; STORE/LOAD -> DONE; DONE -> IDLE.
//    addr/size/sext/wdata latched at the accepting edge; later req_i changes ignored until DONE.
//  - STORE: cycles 1..N after accept: ram_a_o=addr+k, ram_wr_o=1, ram_dout_o=wdata[8k+7:8k].
//    Cycle N+1: DONE, ready_o=1, ram_wr_o=0. Latency accept->ready_o = N+1 cycles.
//  - LOAD: cycles 1..N: ram_a_o=addr+k, ram_wr_o=0. ram_din_i captured at end of cycles 2..N+1
//    into byte k-1 of assembly reg. Cycle N+2: DONE, ready_o=1, rdata_o=extended value.
//    Latency accept->ready_o = N+2 cycles.
//  - Extension: byte -> bits[31:8] = sext ? {24{b[7]}} : 0; half -> bits[31:16] likewise on b[15].
//  - ready_o high exactly one cycle; rdata_o=0 when ready_o=0. In IDLE: ram_wr_o=0, ram_a_o holds.
//  - stall_o = req_i & ~ready_o: pipeline advances in the ready_o cycle. A new request is
//    accepted only in IDLE, so back-to-back requests have one IDLE gap after DONE.
//  - Address wrap: addr 0x1FFFF word with RAM_AW=17 -> bytes at 0x1FFFF,0x00000,0x00001,0x00002.
//  - req_i deasserted mid-op (flush): op still completes; ready_o still pulses.
// TESTING
//  1. Store word 0xDEADBEEF @0x100 -> wr cycles 1-4: a=100..103, dout EF,BE,AD,DE; ready_o cycle 5.
//  2. Load word @0x100 after (1) -> ready_o cycle 6, rdata_o=0xDEADBEEF; stall_o=1 cycles 0-5.
//  3. RAM[0x200]=0x80: load byte sext=1 -> 0xFFFFFF80; sext=0 -> 0x00000080; ready_o cycle 3.
//  4. Store half 0x1234 @0x1FFFF -> writes 34@0x1FFFF, 12@0x00000; load half sext=0 -> 0x00001234.
//  5. rst=0 during cycle 2 of word store -> from next cycle ram_wr_o=0, ready_o never pulses,
//     RAM holds only bytes 0-1; after release, new load accepted normally.
//  6. req_i held high after ready_o -> one IDLE cycle, then second request accepted; no lost op.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial load/store responder between the MEM stage and an 8-bit RAM port.
// Little-endian, one byte per cycle; loads are zero- or sign-extended on completion.
module mem_ctrl #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        size_i,
    input  logic              sext_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic              stall_o,
    output logic [RAM_AW-1:0] ram_a_o,
    output logic              ram_wr_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_STORE = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [2:0]  last;
    logic [1:0]  size_q;
    logic        sext_q;
    logic [23:0] wsh_q;
    logic [31:0] asm_q;
    logic        unused_addr;

    function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] sz,
                                           input logic sx);
        case (sz)
            2'b00:   extend = {{24{sx & v[7]}}, v[7:0]};
            2'b01:   extend = {{16{sx & v[15]}}, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    assign unused_addr = ^addr_i[31:RAM_AW];
    assign last    = (size_q == 2'b00) ? 3'd0 : (size_q == 2'b01) ? 3'd1 : 3'd3;
    assign stall_o = req_i & ~ready_o;
    assign rdata_o = ready_o ? extend(asm_q, size_q, sext_q) : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= 3'd0;
            ram_a_o    <= '0;
            ram_wr_o   <= 1'b0;
            ram_dout_o <= 8'h00;
            ready_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b0;
                    if (req_i) begin
                        state    <= we_i ? S_STORE : S_LOAD;
                        cnt      <= 3'd0;
                        ram_a_o  <= addr_i[RAM_AW-1:0];
                        ram_wr_o <= we_i;
                        if (we_i)
                            ram_dout_o <= wdata_i[7:0];
                    end
                end
                S_STORE: begin
                    if (cnt == last) begin
                        state    <= S_DONE;
                        ram_wr_o <= 1'b0;
                        ready_o  <= 1'b1;
                    end else begin
                        cnt        <= cnt + 3'd1;
                        ram_a_o    <= ram_a_o + RAM_AW'(1);
                        ram_dout_o <= wsh_q[7:0];
                    end
                end
                S_LOAD: begin
                    // One extra cycle beyond the last address to catch the final read byte.
                    if (cnt == last + 3'd1) begin
                        state   <= S_DONE;
                        ready_o <= 1'b1;
                    end else begin
                        cnt <= cnt + 3'd1;
                        if (cnt != last)
                            ram_a_o <= ram_a_o + RAM_AW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    ready_o <= 1'b0;
                    cnt     <= 3'd0;
                end
            endcase
        end
    end

    // Datapath registers carry no reset; they are only consumed under control qualifiers.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && req_i) begin
            size_q <= size_i;
            sext_q <= sext_i;
            wsh_q  <= wdata_i[31:8];
        end else if (state == S_STORE) begin
            wsh_q <= {8'h00, wsh_q[23:8]};
        end
        if (state == S_LOAD) begin
            case (cnt)
                3'd1:    asm_q[7:0]   <= ram_din_i;
                3'd2:    asm_q[15:8]  <= ram_din_i;
                3'd3:    asm_q[23:16] <= ram_din_i;
                3'd4:    asm_q[31:24] <= ram_din_i;
                default: ;
            endcase
        end
    end

endmodule
